// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier, its layer sequencer
// and the host wrappers: sequencer states and control/status bit positions.
package mvm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RELEASE = 3'd2,
    ST_COPY    = 3'd3,
    ST_DONE    = 3'd4
  } mvm_state_t;

  // Host-side control/status word layout.
  localparam int HOST_RUN_BIT   = 0;
  localparam int HOST_DONE_BIT  = 0;
  localparam int HOST_LAYER_LSB = 8;
  localparam int HOST_LAYER_W   = 8;

  // Multiplier-side control/status word layout.
  localparam int MVM_START_BIT  = 0;
  localparam int MVM_DONE_BIT   = 0;

  // Clamp negative IEEE-754 words (sign bit set) to +0.0.
  function automatic logic [31:0] relu32(input logic [31:0] w);
    return w[31] ? 32'h0000_0000 : w;
  endfunction

endpackage

// File: rtl/mvm_copy_engine.sv
// Copies LENGTH words from the y BRAM to the x BRAM: one read per cycle,
// each word written one cycle later (after optional ReLU). A start pulse
// launches a run; busy covers the LENGTH+1 cycles and done flags the last.
module mvm_copy_engine
  import mvm_pkg::*;
#(
  parameter int LENGTH    = 128,
  parameter int ADDR_SIZE = 12,
  parameter int RELU      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] addr_y,
  input  logic [31:0]          rddata_y,
  output logic [ADDR_SIZE-1:0] addr_x,
  output logic [31:0]          wrdata_x,
  output logic [3:0]           we_x
);

  // One extra bit so the index can reach LENGTH without wrapping.
  localparam int IW = $clog2(LENGTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(LENGTH);

  logic [IW-1:0]        idx;
  logic [IW+1:0]        byte_addr;
  logic                 rd_active;
  logic                 wr_valid;
  logic [ADDR_SIZE-1:0] wr_addr;

  assign byte_addr = {idx, 2'b00};
  assign rd_active = busy && (idx != LAST);
  assign done      = busy && (idx == LAST);

  // Read side: byte address of the current index, truncated to the port width.
  assign addr_y = rd_active ? ADDR_SIZE'(byte_addr) : '0;

  // Index counter plus the one-cycle delayed write address/valid.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      busy     <= 1'b0;
      idx      <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
    end else begin
      wr_valid <= rd_active;
      wr_addr  <= addr_y;
      if (start) begin
        busy <= 1'b1;
        idx  <= '0;
      end else if (busy) begin
        if (idx == LAST) begin
          busy <= 1'b0;
          idx  <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Write side: data arrives from the BRAM one cycle after its address.
  always_comb begin
    addr_x   = '0;
    wrdata_x = '0;
    we_x     = 4'h0;
    if (wr_valid) begin
      addr_x   = wr_addr;
      wrdata_x = (RELU != 0) ? relu32(rddata_y) : rddata_y;
      we_x     = 4'hf;
    end
  end

endmodule

// File: rtl/mvm_layer_sequencer.sv
// Runs NUM_LAYERS chained matrix-vector products: starts the multiplier,
// waits for its done/release handshake, then copies y back into x before
// the next layer. Reports done and the current layer to the host.
module mvm_layer_sequencer
  import mvm_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int LENGTH     = 128,
  parameter int ADDR_SIZE  = 12,
  parameter int RELU       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          host_control,
  output logic [31:0]          host_status,
  output logic [31:0]          mvm_control,
  input  logic [31:0]          mvm_status,
  output logic                 copy_sel,
  output logic [ADDR_SIZE-1:0] bram_addr_y,
  input  logic [31:0]          bram_rddata_y,
  output logic [ADDR_SIZE-1:0] bram_addr_x,
  output logic [31:0]          bram_wrdata_x,
  output logic [3:0]           bram_we_x
);

  localparam logic [7:0] LAST_LAYER = 8'(NUM_LAYERS - 1);

  mvm_state_t state, state_next;
  logic [7:0] layer;
  logic       run_req;
  logic       mvm_done;
  logic       mvm_start;
  logic       done_flag;
  logic       layer_clr;
  logic       layer_inc;
  logic       copy_start;
  logic       copy_busy;
  logic       copy_done;
  logic       unused_bits;

  assign run_req     = host_control[HOST_RUN_BIT];
  assign mvm_done    = mvm_status[MVM_DONE_BIT];
  assign unused_bits = ^{host_control[31:1], mvm_status[31:1], copy_busy};

  // State register and layer counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      layer <= '0;
    end else begin
      state <= state_next;
      if (layer_clr)      layer <= '0;
      else if (layer_inc) layer <= layer + 8'd1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next = state;
    mvm_start  = 1'b0;
    done_flag  = 1'b0;
    layer_clr  = 1'b0;
    layer_inc  = 1'b0;
    copy_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_req) begin
          state_next = ST_START;
          layer_clr  = 1'b1;
        end
      end
      ST_START: begin
        mvm_start = 1'b1;
        if (mvm_done) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!mvm_done) begin
          if (layer == LAST_LAYER) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_COPY;
            copy_start = 1'b1;
          end
        end
      end
      ST_COPY: begin
        if (copy_done) begin
          state_next = ST_START;
          layer_inc  = 1'b1;
        end
      end
      ST_DONE: begin
        done_flag = 1'b1;
        if (!run_req) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pack the host and multiplier control/status words.
  always_comb begin
    host_status = '0;
    mvm_control = '0;
    host_status[HOST_DONE_BIT] = done_flag;
    host_status[HOST_LAYER_LSB +: HOST_LAYER_W] = layer;
    mvm_control[MVM_START_BIT] = mvm_start;
  end

  assign copy_sel = (state == ST_COPY);

  mvm_copy_engine #(
    .LENGTH   (LENGTH),
    .ADDR_SIZE(ADDR_SIZE),
    .RELU     (RELU)
  ) u_copy (
    .clk     (clk),
    .reset   (reset),
    .start   (copy_start),
    .busy    (copy_busy),
    .done    (copy_done),
    .addr_y  (bram_addr_y),
    .rddata_y(bram_rddata_y),
    .addr_x  (bram_addr_x),
    .wrdata_x(bram_wrdata_x),
    .we_x    (bram_we_x)
  );

endmodule

// File: tb/tb_mvm_layer_sequencer.sv
// Directed bench: three sequencers (3 layers/ReLU, 1 layer, 3 layers/no ReLU)
// each with a behavioural multiplier, y/x BRAM models and activity monitors.
module tb_mvm_layer_sequencer;
  import mvm_pkg::*;

  localparam int LEN = 128;

  logic        clk;
  logic        reset;
  logic [31:0] host_control [3];
  logic        man_mode     [3];
  logic        man_status   [3];
  wire  [31:0] host_status  [3];
  wire  [31:0] mvm_control  [3];
  wire         copy_sel     [3];
  wire  [11:0] addr_y       [3];
  wire  [11:0] addr_x       [3];
  wire  [31:0] wrdata_x     [3];
  wire  [3:0]  we_x         [3];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // y BRAM contents: a few hand-picked floats, the rest a ramp.
  function automatic logic [31:0] y_word(input int i);
    case (i)
      5:       return 32'hC120_0000;
      6:       return 32'h4120_0000;
      7:       return 32'h8000_0007;
      default: return 32'h0100_0000 + 32'(i);
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int NL = (k == 1) ? 1 : 3;
    localparam int RL = (k == 2) ? 0 : 1;

    logic [31:0] rdy;
    logic [31:0] mstat;
    logic [31:0] xmem [LEN];
    logic        st;
    int          cnt;
    int          pulses, runs, last_len, cur_len, len_bad, wr_cnt;
    logic        prev_start, we_seen, sel_seen, we_bad;

    mvm_layer_sequencer #(
      .NUM_LAYERS(NL), .LENGTH(LEN), .ADDR_SIZE(12), .RELU(RL)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .host_control (host_control[k]),
      .host_status  (host_status[k]),
      .mvm_control  (mvm_control[k]),
      .mvm_status   (mstat),
      .copy_sel     (copy_sel[k]),
      .bram_addr_y  (addr_y[k]),
      .bram_rddata_y(rdy),
      .bram_addr_x  (addr_x[k]),
      .bram_wrdata_x(wrdata_x[k]),
      .bram_we_x    (we_x[k])
    );

    // Multiplier model: done 50 cycles after start, cleared once start drops.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        st  <= 1'b0;
        cnt <= 0;
      end else if (mvm_control[k][0] && !st) begin
        if (cnt == 49) st <= 1'b1;
        else           cnt <= cnt + 1;
      end else if (!mvm_control[k][0] && st) begin
        st  <= 1'b0;
        cnt <= 0;
      end
    end
    assign mstat = {31'b0, man_mode[k] ? man_status[k] : st};

    // y BRAM read port with one cycle of latency.
    always @(posedge clk) rdy <= y_word(int'(addr_y[k] >> 2));

    // x BRAM write port.
    always @(posedge clk) if (we_x[k] == 4'hf) xmem[addr_x[k][8:2]] <= wrdata_x[k];

    // Activity monitors: start pulses, copy run lengths, write strobes.
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        pulses <= 0; runs <= 0; last_len <= 0; cur_len <= 0; len_bad <= 0;
        wr_cnt <= 0; prev_start <= 1'b0; we_seen <= 1'b0; sel_seen <= 1'b0;
        we_bad <= 1'b0;
      end else begin
        prev_start <= mvm_control[k][0];
        if (mvm_control[k][0] && !prev_start) pulses <= pulses + 1;
        if (copy_sel[k]) begin
          cur_len  <= cur_len + 1;
          sel_seen <= 1'b1;
        end else if (cur_len != 0) begin
          runs     <= runs + 1;
          last_len <= cur_len;
          if (cur_len != LEN + 1) len_bad <= len_bad + 1;
          cur_len  <= 0;
        end
        if (we_x[k] != 4'h0) we_seen <= 1'b1;
        if (we_x[k] == 4'hf) wr_cnt <= wr_cnt + 1;
        if ((we_x[k] != 4'h0 && we_x[k] != 4'hf) || (we_x[k] != 4'h0 && !copy_sel[k]))
          we_bad <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int k, input int max_c, input string tag);
    int n = 0;
    while (host_status[k][0] !== 1'b1 && n < max_c) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(host_status[k][0]), 32'd1);
  endtask

  initial begin
    int  n;
    logic flag;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_control[i] = '0;
      man_mode[i]     = 1'b0;
      man_status[i]   = 1'b0;
    end
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_host_status", host_status[0], 32'h0);
    check("rst_mvm_control", mvm_control[0], 32'h0);
    check("rst_copy_sel",    32'(copy_sel[0]), 32'h0);
    check("rst_we_x",        32'(we_x[0]), 32'h0);
    check("rst_addr_y",      32'(addr_y[0]), 32'h0);
    check("rst_state",       32'(g[0].dut.state), 32'(ST_IDLE));

    // Run request honoured on the first edge after reset release.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) host_control[i] = 32'h1;
    @(negedge clk);
    check("first_edge_start", mvm_control[0], 32'h1);
    check("first_edge_state", 32'(g[0].dut.state), 32'(ST_START));
    check("first_status",     host_status[0], 32'h0);
    repeat (2) @(negedge clk);
    host_control[1] = 32'h0;   // drops in START must be ignored
    host_control[2] = 32'h0;

    // Single-layer run: no copy at all.
    wait_done(1, 200, "nl1_done");
    check("nl1_start_pulses", 32'(g[1].pulses), 32'd1);
    check("nl1_we_never",     32'(g[1].we_seen), 32'd0);
    check("nl1_sel_never",    32'(g[1].sel_seen), 32'd0);

    // Three-layer runs, without and with ReLU.
    wait_done(2, 1000, "relu0_done");
    check("relu0_neg_word",  g[2].xmem[5], 32'hC120_0000);
    check("relu0_neg_small", g[2].xmem[7], 32'h8000_0007);
    check("relu0_pos_word",  g[2].xmem[6], 32'h4120_0000);
    check("l3_status_done",  host_status[0], 32'h0000_0201);
    check("l3_start_pulses", 32'(g[0].pulses), 32'd3);
    check("l3_copy_runs",    32'(g[0].runs), 32'd2);
    check("l3_copy_len",     32'(g[0].last_len), 32'd129);
    check("l3_copy_len_bad", 32'(g[0].len_bad), 32'd0);
    check("l3_write_count",  32'(g[0].wr_cnt), 32'd256);
    check("l3_we_legal",     32'(g[0].we_bad), 32'd0);
    check("relu_neg_word",   g[0].xmem[5], 32'h0000_0000);
    check("relu_neg_small",  g[0].xmem[7], 32'h0000_0000);
    check("relu_pos_word",   g[0].xmem[6], 32'h4120_0000);
    check("copy_first_word", g[0].xmem[0], 32'h0100_0000);
    check("copy_last_word",  g[0].xmem[127], 32'h0100_007F);

    // Run held high through DONE: no restart.
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mvm_control[0][0] !== 1'b0 || host_status[0][0] !== 1'b1) flag = 1'b1;
    end
    check("hold_no_restart", 32'(flag), 32'd0);
    check("hold_pulses",     32'(g[0].pulses), 32'd3);
    host_control[0] = 32'h0;
    @(negedge clk);
    check("drop_done_clear", 32'(host_status[0][0]), 32'd0);
    check("drop_state_idle", 32'(g[0].dut.state), 32'(ST_IDLE));
    host_control[0] = 32'h1;
    @(negedge clk);
    check("rerun_layer0", host_status[0], 32'h0);
    check("rerun_start",  mvm_control[0], 32'h1);

    // Reset in the middle of COPY, at index 60.
    n = 0;
    while (!(copy_sel[0] === 1'b1 && addr_y[0] === 12'd240) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx60", 32'(copy_sel[0] === 1'b1 && addr_y[0] === 12'd240), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_copy_sel", 32'(copy_sel[0]), 32'd0);
    check("abort_we_x",     32'(we_x[0]), 32'd0);
    check("abort_addr_y",   32'(addr_y[0]), 32'd0);
    check("abort_state",    32'(g[0].dut.state), 32'(ST_IDLE));
    @(negedge clk);
    check("abort_next_outs", {host_status[0] | mvm_control[0] | wrdata_x[0]}, 32'h0);
    check("abort_next_addr", {19'b0, addr_x[0], we_x[0]} | 32'(copy_sel[0]), 32'h0);
    reset = 1'b0;
    wait_done(0, 1000, "rerun_done");
    check("rerun_pulses",  32'(g[0].pulses), 32'd3);
    check("rerun_runs",    32'(g[0].runs), 32'd2);
    check("rerun_len_bad", 32'(g[0].len_bad), 32'd0);
    check("rerun_writes",  32'(g[0].wr_cnt), 32'd256);
    host_control[0] = 32'h0;

    // Multiplier already done when START is entered.
    man_mode[1]     = 1'b1;
    man_status[1]   = 1'b1;
    host_control[1] = 32'h1;
    @(negedge clk);
    check("pre_done_start", mvm_control[1], 32'h1);
    @(negedge clk);
    check("start_one_cycle", mvm_control[1], 32'h0);
    check("release_entered", 32'(g[1].dut.state), 32'(ST_RELEASE));
    host_control[1] = 32'h0;
    repeat (4) @(negedge clk);
    check("release_holds",   32'(g[1].dut.state), 32'(ST_RELEASE));
    check("release_no_done", 32'(host_status[1][0]), 32'd0);
    man_status[1] = 1'b0;
    @(negedge clk);
    check("release_to_done", host_status[1], 32'h1);
    @(negedge clk);
    check("done_to_idle", 32'(g[1].dut.state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
